booth_r4_seq_mult: RTL

- Parametrised sequential radix-4 Booth multiplier; next generation of the team's 9-bit radix-2 Booth datapath/controlpath pair.
- Parallel operand load replaces serial loading via data_in.
- Adds a run-time signed/unsigned mode, a ready/start handshake with back-to-back issue, and two multiplier bits retired per cycle.
- Sits in the arithmetic unit as a multi-cycle multiply resource.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_r4_recode.sv | 21 ++
 rtl/booth_r4_seq_mult.sv | 123 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier family.
//   state_t : controller states (IDLE, CALC, DONE)
//   digit_t : recoded Booth digit {neg, two, nonzero}
//   calc_k  : Booth digit count for an N-bit operand
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Digit value = (nonzero ? (two ? 2 : 1) : 0) * (neg ? -1 : +1)
    typedef struct packed {
        logic neg;
        logic two;
        logic nonzero;
    } digit_t;

    // ceil((n+1)/2): enough digits to cover an n-bit operand plus one
    // extension bit, so unsigned operands never see a negative top digit.
    function automatic int unsigned calc_k(input int unsigned n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// booth_r4_recode: combinational radix-4 Booth recoder.
//   window : multiplier bits {2i+1, 2i, 2i-1}
//   digit  : recoded digit {neg, two, nonzero}
module booth_r4_recode
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output digit_t     digit
);

    always_comb begin
        // 100 -> -2, 101/110 -> -1; 111 is zero, so it is not negative
        digit.neg     = window[2] & ~(window[1] & window[0]);
        // 011 -> +2, 100 -> -2
        digit.two     = (window[2] & ~window[1] & ~window[0]) |
                        (~window[2] & window[1] & window[0]);
        // 000 and 111 both recode to zero
        digit.nonzero = ~((window[2] == window[1]) && (window[1] == window[0]));
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, two multiplier
// bits retired per cycle, K = N/2+1 compute cycles per operation.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   start       : request, accepted only while in_ready=1
//   in_ready    : a new operation can be accepted this cycle
//   a, b        : multiplicand / multiplier, sampled on accept
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   busy        : operation in progress
//   done        : one-cycle pulse, product valid
//   product     : full 2N-bit result, held until the next done
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           signed_mode,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned K  = calc_k(N);
    localparam int unsigned LW = 2 * K;        // extended multiplier width
    localparam int unsigned HW = N + 3;        // partial-sum width
    localparam int unsigned AW = HW + LW;      // accumulator width
    localparam int unsigned CW = $clog2(K + 1);

    state_t        state, state_next;
    logic          accept;
    logic          last;
    logic [CW-1:0] cnt;
    logic [N+1:0]  mcand;      // multiplicand extended to N+2 bits
    logic [AW-1:0] acc;        // {partial sum, unretired multiplier bits}
    logic [AW-1:0] acc_next;
    logic          qm1;        // multiplier bit just below the current window
    digit_t        digit;
    logic [HW-1:0] pp;
    logic [HW-1:0] pp_sel;
    logic [HW-1:0] hi_sum;

    booth_r4_recode u_recode (
        .window ({acc[1], acc[0], qm1}),
        .digit  (digit)
    );

    assign last = (cnt == CW'(K - 1));

    // Partial-sum step. The high part carries one guard bit beyond the
    // N+2-bit multiplicand so the running sum plus a +-2x term never wraps.
    always_comb begin
        pp = digit.two ? {mcand, 1'b0} : {mcand[N+1], mcand};
        if (!digit.nonzero) begin
            pp = '0;
        end
        pp_sel   = digit.neg ? ~pp : pp;
        hi_sum   = acc[AW-1:LW] + pp_sel + HW'(digit.neg);
        acc_next = {{2{hi_sum[HW-1]}}, hi_sum, acc[LW-1:2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = start;
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done     = 1'b1;
                in_ready = 1'b1;
                accept   = start;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            mcand <= {{2{signed_mode & a[N-1]}}, a};
            acc   <= {{HW{1'b0}}, {(LW-N){signed_mode & b[N-1]}}, b};
            qm1   <= 1'b0;
            cnt   <= '0;
        end else if (state == CALC) begin
            acc <= acc_next;
            qm1 <= acc[1];
            cnt <= cnt + CW'(1);
            // Registered on the last digit so it is valid while done is high
            if (last) begin
                product <= acc_next[2*N-1:0];
            end
        end
    end

endmodule
